// File: rtl/puller_pkg.sv
// Shared definitions for the pusher/puller item stream.
// BITS is the item width used on both sides of the link.
package puller_pkg;

    localparam int BITS = 8;

endpackage

// File: rtl/puller_fifo.sv
// Circular item buffer: storage array, head/tail pointers and occupancy count.
// Pointers wrap by natural overflow, so DEPTH must be a power of two.
module puller_fifo #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [BITS-1:0] data_i,
    output logic [BITS-1:0] data_o,
    output logic [CW-1:0]   count_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d = head_q + 1'b1;
        end
        if (do_push) begin
            tail_d = tail_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; contents behind the head are don't-care.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem_q[tail_q] <= data_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[head_q];

endmodule

// File: rtl/puller.sv
// Puller: receives a bubble-encoded item stream (0 = no item) into a small buffer,
// drops items arriving while full and records that in a sticky overflow flag.
module puller #(
    parameter int BITS  = puller_pkg::BITS,
    parameter int DEPTH = 4,
    parameter int ID    = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [BITS-1:0]            item_in,
    input  logic                       item_pop,
    output logic [BITS-1:0]            item_out,
    output logic                       item_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("puller: DEPTH must be a power of two and at least 2");
    end

    logic has_item, pop_ok, accept, drop;
    logic fifo_full, fifo_empty;
    logic overflow_q, overflow_d;

    always_comb begin
        has_item   = (item_in != '0);
        pop_ok     = item_pop && !fifo_empty;
        accept     = has_item && (!fifo_full || pop_ok);
        drop       = has_item && fifo_full && !pop_ok;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    puller_fifo #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (pop_ok),
        .data_i  (item_in),
        .data_o  (item_out),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign item_valid = !fifo_empty;
    assign full       = fifo_full;
    assign overflow   = overflow_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            $display("(puller %0d): I pulled item %0d", ID, item_in);
        end
        if (!reset && drop) begin
            $display("(puller %0d): dropped item %0d", ID, item_in);
        end
    end
`endif

endmodule

// File: doc/puller.md
PULLER -- requirements
Module: puller

Interface
REQ-001 Parameter BITS, default 8: item width; the value SHALL come from the shared BITS constant.
REQ-002 Parameter DEPTH, default 4: buffer entries; SHALL be a power of two, 2 or more.
REQ-003 Parameter ID, default 0: instance number for simulation log messages.
REQ-004 clock  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 item_in  input  BITS  item stream from an upstream pusher; value 0 = no item (bubble).
REQ-007 item_pop  input  1  consumer accepts the head item this cycle.
REQ-008 item_out  output  BITS  head-of-buffer item; 0 when empty.
REQ-009 item_valid  output  1  high when the buffer holds at least one item.
REQ-010 full  output  1  high when count equals DEPTH.
REQ-011 count  output  clog2(DEPTH+1)  number of buffered items.
REQ-012 overflow  output  1  sticky flag: an item was dropped.

Function
REQ-013 Push: at each rising edge where item_in != 0 and the buffer accepts, the puller SHALL write item_in at the tail.
REQ-014 Each cycle with nonzero item_in SHALL count as one item; repeated equal values on consecutive cycles SHALL be stored as separate items.
REQ-015 Pop: at each rising edge where item_valid and item_pop are both high, the puller SHALL remove the head item; item_pop while empty SHALL be ignored.
REQ-016 Acceptance: a push SHALL be accepted when not full, or when full and a pop occurs in the same cycle.
REQ-017 Latency: an item pushed at edge N into an empty buffer SHALL appear on item_out, with item_valid high, directly after edge N; there SHALL be no combinational bypass from item_in to item_out.
REQ-018 item_out, item_valid, full, count, and overflow SHALL be derived only from registered state.
REQ-019 Push and pop at the same edge when non-empty: count SHALL be unchanged, the head SHALL advance, and the new item SHALL go to the tail.
REQ-020 Push and pop at the same edge when empty: the push SHALL occur and the pop SHALL be ignored, giving count = 1.
REQ-021 Drop: nonzero item_in while full with no pop SHALL leave the buffer unchanged and set overflow, which stays set until reset.
REQ-022 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-023 In simulation, each accepted item SHALL log "(puller ID): I pulled item X".
REQ-024 In simulation, each dropped item SHALL log "(puller ID): dropped item X".

Reset
REQ-025 While reset is high, the block SHALL clear head, tail, count, and overflow, and storage contents SHALL be don't-care.
REQ-026 Outputs during reset SHALL be: item_out = 0, item_valid = 0, full = 0, count = 0, overflow = 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered items immediately, without waiting for a clock edge.
REQ-028 No push or pop SHALL occur at a clock edge where reset is high.

Structure
REQ-029 BITS SHALL live in the shared defines/package used by pusher; DEPTH and ID SHALL stay local parameters.
REQ-030 Storage array, pointers, and count SHALL form one sub-module, puller_fifo.
REQ-031 The top level SHALL contain only bubble detection, accept/drop logic, the overflow flag, and logging.

Verification
REQ-032 Reset, then item_in = 5 for one cycle -> after that edge, item_out = 5, item_valid = 1, count = 1.
REQ-033 Stream 1, 2, 3, 4 with no pop, DEPTH = 4 -> full = 1, count = 4; then item_in = 9 -> overflow = 1, count = 4, head = 1.
REQ-034 Full buffer holding 1..4, item_in = 7 with item_pop = 1 -> item_out = 2, count = 4, overflow = 0; draining then yields 2, 3, 4, 7.
REQ-035 Empty buffer, item_in = 6 with item_pop = 1 -> count = 1, item_out = 6.
REQ-036 Bubbles: item_in sequence 3, 0, 0, 3 -> exactly two items stored (3, 3); more than 2*DEPTH push/pop cycles -> pointer wrap preserves order.
REQ-037 Assert reset asynchronously mid-cycle with count = 3 -> all outputs 0 before the next edge; overflow cleared.
